// File: rtl/reg_file_io.sv
// rtl/reg_file_io.sv - register file with a memory-mapped bidirectional I/O port
// Two registered read ports, write-first bypass, synchronized pin inputs with change detect.
module reg_file_io #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int DIR_ADDR  = DEPTH - 2,
  parameter int PORT_ADDR = DEPTH - 1,
  localparam int AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             WE,
  input  logic [AW-1:0]    WSEL,
  input  logic [WIDTH-1:0] IN,
  input  logic [AW-1:0]    RSEL_A,
  input  logic [AW-1:0]    RSEL_B,
  output logic [WIDTH-1:0] OUT_A,
  output logic [WIDTH-1:0] OUT_B,
  inout  wire  [WIDTH-1:0] PORT,
  output logic             PORT_CHG
);

  localparam logic [AW:0]   DEPTH_W  = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] PORT_SEL = AW'(PORT_ADDR);

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic [WIDTH-1:0] out_a_q, out_a_d;
  logic [WIDTH-1:0] out_b_q, out_b_d;
  logic [WIDTH-1:0] s1_q, s1_d;
  logic [WIDTH-1:0] s2_q, s2_d;
  logic [WIDTH-1:0] s3_q, s3_d;
  logic             chg_q, chg_d;

  logic [WIDTH-1:0] dir_w;
  logic [WIDTH-1:0] latch_w;
  logic [WIDTH-1:0] port_view;
  logic             wr_ok;

  assign dir_w     = regs_q[DIR_ADDR];
  assign latch_w   = regs_q[PORT_ADDR];
  assign port_view = (latch_w & dir_w) | (s2_q & ~dir_w);
  assign wr_ok     = WE && ({1'b0, WSEL} < DEPTH_W);

  // Bypass first so a same-edge write to any address, including the port, wins.
  function automatic logic [WIDTH-1:0] read_sel(input logic [AW-1:0] sel);
    if (wr_ok && (sel == WSEL)) return IN;
    if ({1'b0, sel} >= DEPTH_W) return '0;
    if (sel == PORT_SEL) return port_view;
    return regs_q[sel];
  endfunction

  always_comb begin
    regs_d = regs_q;
    if (wr_ok) regs_d[WSEL] = IN;
    out_a_d = read_sel(RSEL_A);
    out_b_d = read_sel(RSEL_B);
    s1_d    = PORT;
    s2_d    = s1_q;
    s3_d    = s2_q;
    // Mask with the DIR value taking effect this edge so a bit turning into an output never pulses.
    chg_d   = |((s2_q ^ s3_q) & ~regs_d[DIR_ADDR]);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      out_a_q <= '0;
      out_b_q <= '0;
      s1_q    <= '0;
      s2_q    <= '0;
      s3_q    <= '0;
      chg_q   <= 1'b0;
    end else begin
      regs_q  <= regs_d;
      out_a_q <= out_a_d;
      out_b_q <= out_b_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      s3_q    <= s3_d;
      chg_q   <= chg_d;
    end
  end

  assign OUT_A    = out_a_q;
  assign OUT_B    = out_b_q;
  assign PORT_CHG = chg_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    assign PORT[i] = dir_w[i] ? latch_w[i] : 1'bz;
  end

endmodule

// File: tb/tb_reg_file_io.sv
// tb/tb_reg_file_io.sv - scoreboard bench for reg_file_io with randomized stimulus
// Non-power-of-two DEPTH so out-of-range addresses are reachable.
module tb_reg_file_io;

  localparam int WIDTH     = 8;
  localparam int DEPTH     = 12;
  localparam int AW        = 4;
  localparam int DIR_ADDR  = DEPTH - 2;
  localparam int PORT_ADDR = DEPTH - 1;

  logic             CLK = 1'b0;
  logic             RST_N = 1'b0;
  logic             WE = 1'b0;
  logic [AW-1:0]    WSEL = '0;
  logic [WIDTH-1:0] IN = '0;
  logic [AW-1:0]    RSEL_A = '0;
  logic [AW-1:0]    RSEL_B = '0;
  wire  [WIDTH-1:0] OUT_A;
  wire  [WIDTH-1:0] OUT_B;
  wire  [WIDTH-1:0] PORT;
  wire              PORT_CHG;

  logic [WIDTH-1:0] ext_val = '0;
  logic [WIDTH-1:0] ext_oe  = '1;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ext
    assign PORT[i] = ext_oe[i] ? ext_val[i] : 1'bz;
  end

  reg_file_io #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST_N(RST_N), .WE(WE), .WSEL(WSEL), .IN(IN),
    .RSEL_A(RSEL_A), .RSEL_B(RSEL_B), .OUT_A(OUT_A), .OUT_B(OUT_B),
    .PORT(PORT), .PORT_CHG(PORT_CHG)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             chg;
  } exp_t;

  exp_t             exp_q[$];
  int               checks = 0;
  int               errors = 0;
  bit               mon_en = 1'b0;
  logic [WIDTH-1:0] m_mem [DEPTH];
  logic [WIDTH-1:0] m_pins[$];   // pin samples, newest first: [0]=S1, [1]=S2, [2]=S3
  logic [WIDTH-1:0] ev;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    m_pins = '{8'h00, 8'h00, 8'h00};
    exp_q.delete();
  endtask

  function automatic logic [WIDTH-1:0] m_read(input logic we, input logic [AW-1:0] wsel,
                                              input logic [WIDTH-1:0] din, input logic [AW-1:0] sel);
    logic [WIDTH-1:0] dir;
    dir = m_mem[DIR_ADDR];
    if (we && wsel == sel && int'(sel) < DEPTH) return din;
    if (int'(sel) >= DEPTH) return '0;
    if (int'(sel) == PORT_ADDR) return (m_mem[PORT_ADDR] & dir) | (m_pins[1] & ~dir);
    return m_mem[sel];
  endfunction

  // One clock of stimulus; predicts what the DUT shows after the coming rising edge.
  task automatic step(input logic we, input logic [AW-1:0] wsel, input logic [WIDTH-1:0] din,
                      input logic [AW-1:0] ra, input logic [AW-1:0] rb, input logic [WIDTH-1:0] evi);
    logic [WIDTH-1:0] dir_old, dir_new, rising, drive, pin;
    exp_t e;
    @(negedge CLK);
    dir_old = m_mem[DIR_ADDR];
    dir_new = (we && int'(wsel) == DIR_ADDR) ? din : dir_old;
    rising  = dir_new & ~dir_old;
    // Pins about to become outputs are held at the latch value so the handover is glitch-free.
    drive   = (evi & ~rising) | (m_mem[PORT_ADDR] & rising);
    WE = we; WSEL = wsel; IN = din; RSEL_A = ra; RSEL_B = rb;
    ext_val = drive;
    ext_oe  = ~dir_old;
    pin   = (dir_old & m_mem[PORT_ADDR]) | (~dir_old & drive);
    e.a   = m_read(we, wsel, din, ra);
    e.b   = m_read(we, wsel, din, rb);
    e.chg = |((m_pins[1] ^ m_pins[2]) & ~dir_new);
    if (we && int'(wsel) < DEPTH) m_mem[wsel] = din;
    m_pins.push_front(pin);
    void'(m_pins.pop_back());
    exp_q.push_back(e);
  endtask

  task automatic idle(input logic [AW-1:0] ra, input logic [WIDTH-1:0] evi);
    step(1'b0, '0, '0, ra, ra, evi);
  endtask

  always begin : monitor
    exp_t e;
    @(posedge CLK);
    #1;
    if (mon_en && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("sb_out_a", OUT_A, e.a);
      chk("sb_out_b", OUT_B, e.b);
      chk("sb_port_chg", PORT_CHG, e.chg);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    ev = '0;
    #12;
    chk("reset_out_a", OUT_A, 0);
    chk("reset_out_b", OUT_B, 0);
    chk("reset_port_chg", PORT_CHG, 0);
    @(negedge CLK);
    RST_N  = 1'b1;
    mon_en = 1'b1;

    // Dual read
    step(1'b1, 4'd3, 8'h5A, 4'd0, 4'd0, ev);
    step(1'b1, 4'd7, 8'hC3, 4'd0, 4'd0, ev);
    idle(4'd3, ev);
    step(1'b0, '0, '0, 4'd3, 4'd7, ev);
    @(posedge CLK); #2;
    chk("dual_out_a", OUT_A, 8'h5A);
    chk("dual_out_b", OUT_B, 8'hC3);

    // Write-first bypass onto r5 (still zero)
    step(1'b1, 4'd5, 8'h81, 4'd5, 4'd5, ev);
    @(posedge CLK); #2;
    chk("bypass_out_a", OUT_A, 8'h81);

    // Output port: low nibble driven, high nibble from pins
    ev = 8'h90;
    step(1'b1, 4'(DIR_ADDR), 8'h0F, 4'd0, 4'd0, ev);
    step(1'b1, 4'(PORT_ADDR), 8'hA5, 4'd0, 4'd0, ev);
    idle(4'd0, ev);
    idle(4'd0, ev);
    step(1'b0, '0, '0, 4'(PORT_ADDR), 4'(DIR_ADDR), ev);
    @(posedge CLK); #2;
    chk("port_read", OUT_A, 8'h95);
    chk("dir_read", OUT_B, 8'h0F);
    chk("port_pins_low", {4'h0, PORT[3:0]}, 8'h05);

    // Change detect on input pin 0
    ev = 8'h00;
    step(1'b1, 4'(DIR_ADDR), 8'h00, 4'd0, 4'd0, ev);
    for (int i = 0; i < 4; i++) idle(4'd0, ev);
    ev = 8'h01;
    for (int k = 0; k < 4; k++) begin
      idle(4'd0, ev);
      @(posedge CLK); #2;
      chk($sformatf("chg_edge_n+%0d", k), PORT_CHG, (k == 2) ? 1 : 0);
    end

    // Toggling an output bit never pulses
    step(1'b1, 4'(DIR_ADDR), 8'h01, 4'd0, 4'd0, ev);
    for (int i = 0; i < 3; i++) idle(4'd0, ev);
    for (int k = 0; k < 6; k++) begin
      if (k < 4) step(1'b1, 4'(PORT_ADDR), (k % 2 == 0) ? 8'h00 : 8'h01, 4'd0, 4'd0, ev);
      else idle(4'd0, ev);
      @(posedge CLK); #2;
      chk("chg_output_toggle", PORT_CHG, 0);
    end

    // Out-of-range write and reads
    step(1'b1, 4'(DEPTH), 8'hEE, 4'(DEPTH), 4'(DEPTH + 1), ev);
    @(posedge CLK); #2;
    chk("bounds_out_a", OUT_A, 0);
    chk("bounds_out_b", OUT_B, 0);

    // Randomized traffic checked by the scoreboard
    for (int n = 0; n < 600; n++) begin
      logic [AW-1:0] ra;
      if ($urandom_range(0, 3) == 0) ev = WIDTH'($urandom());
      ra = AW'($urandom_range(0, 15));
      step(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), WIDTH'($urandom()), ra,
           ($urandom_range(0, 4) == 0) ? ra : AW'($urandom_range(0, 15)), ev);
    end

    // Asynchronous reset mid-cycle with state nonzero
    step(1'b1, 4'd1, 8'h77, 4'd1, 4'd1, ev);
    @(posedge CLK); #3;
    mon_en = 1'b0;
    RST_N = 1'b0;
    #1;
    chk("midrst_out_a", OUT_A, 0);
    chk("midrst_out_b", OUT_B, 0);
    chk("midrst_port_chg", PORT_CHG, 0);
    ev = '0;
    ext_val = '0;
    ext_oe = '1;
    WE = 1'b1; WSEL = 4'd0; IN = 8'hFF;
    @(posedge CLK);
    @(posedge CLK);
    @(negedge CLK); #1;
    RST_N = 1'b1;
    WE = 1'b0;
    model_reset();
    mon_en = 1'b1;
    step(1'b0, '0, '0, 4'd0, 4'd1, ev);
    @(posedge CLK); #2;
    chk("postrst_r0", OUT_A, 0);
    chk("postrst_r1", OUT_B, 0);
    step(1'b1, 4'd2, 8'h33, 4'd0, 4'(DIR_ADDR), ev);
    step(1'b0, '0, '0, 4'd2, 4'(PORT_ADDR), ev);
    @(posedge CLK); #2;
    chk("postrst_write", OUT_A, 8'h33);

    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 3) == 0) ev = WIDTH'($urandom());
      step(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), WIDTH'($urandom()),
           AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15)), ev);
    end
    @(posedge CLK); #3;
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
